iir_coef_loader: RTL



---
 rtl/iir_coef_loader_if.sv | 12 +
 rtl/iir_coef_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/iir_coef_loader_if.sv
// Coefficient word stream into the loader: valid/ready handshake plus data word.
// The master drives wr_vld/wr_data; the loader (slave) returns wr_rdy.
interface iir_coef_loader_if #(
    parameter int CWIDTH = 24
);
    logic              wr_vld;
    logic              wr_rdy;
    logic [CWIDTH-1:0] wr_data;

    modport master (output wr_vld, output wr_data, input wr_rdy);
    modport slave  (input wr_vld, input wr_data, output wr_rdy);
endinterface

// File: rtl/iir_coef_loader.sv
// Purpose: shadow-buffers a biquad coefficient set and commits it atomically to coefs on a din_vld sample boundary.
// Latency: coefs/coef_upd change one cycle after the committing din_vld; all outputs are registered.
// Backpressure: wr_rdy is high only in LOAD. Optional checksum word via macro IIR_COEF_CHKSUM_EN.
module iir_coef_loader #(
    parameter int CASCADE_LEVEL = 10,
    parameter int CWIDTH        = 24
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              block_en,
    input  logic                              din_vld,
    input  logic                              load_start,
    iir_coef_loader_if.slave                  wr,
    output logic [CASCADE_LEVEL*CWIDTH*5-1:0] coefs,
    output logic                              load_busy,
    output logic                              coef_upd
`ifdef IIR_COEF_CHKSUM_EN
    ,
    output logic                              load_err
`endif
);

    localparam int N   = CASCADE_LEVEL * 5;
    localparam int WCW = $clog2(N + 1);
    localparam int BW  = N * CWIDTH;
    localparam logic [WCW-1:0] LAST_IDX = WCW'(N - 1);
`ifdef IIR_COEF_CHKSUM_EN
    localparam logic [WCW-1:0] CHK_IDX  = WCW'(N);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t            state;
    logic [WCW-1:0]    wcnt;
    logic [BW-1:0]     shadow;
    logic              wr_rdy_q;
    logic              xfer;
    logic [CWIDTH-1:0] wr_data;
`ifdef IIR_COEF_CHKSUM_EN
    logic [CWIDTH-1:0] acc;
`endif

    assign wr.wr_rdy = wr_rdy_q;
    assign wr_data   = wr.wr_data;
    assign xfer      = wr.wr_vld & wr_rdy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wcnt      <= '0;
            shadow    <= '0;
            coefs     <= '0;
            wr_rdy_q  <= 1'b0;
            load_busy <= 1'b0;
            coef_upd  <= 1'b0;
`ifdef IIR_COEF_CHKSUM_EN
            acc       <= '0;
            load_err  <= 1'b0;
`endif
        end else begin
            coef_upd <= 1'b0;
            if (!block_en) begin
                // Abort keeps both shadow and active set; only the sequencing is dropped.
                state     <= IDLE;
                wcnt      <= '0;
                wr_rdy_q  <= 1'b0;
                load_busy <= 1'b0;
`ifdef IIR_COEF_CHKSUM_EN
                load_err  <= 1'b0;
`endif
            end else if (load_start) begin
                // Restart wins over any same-cycle transfer or commit.
                state     <= LOAD;
                wcnt      <= '0;
                wr_rdy_q  <= 1'b1;
                load_busy <= 1'b1;
`ifdef IIR_COEF_CHKSUM_EN
                acc       <= '0;
                load_err  <= 1'b0;
`endif
            end else begin
                case (state)
                    LOAD: begin
                        if (xfer) begin
`ifdef IIR_COEF_CHKSUM_EN
                            if (wcnt == CHK_IDX) begin
                                wcnt     <= '0;
                                wr_rdy_q <= 1'b0;
                                if (wr_data == acc) begin
                                    state <= PENDING;
                                end else begin
                                    state     <= IDLE;
                                    load_busy <= 1'b0;
                                    load_err  <= 1'b1;
                                end
                            end else begin
                                shadow[int'(wcnt)*CWIDTH +: CWIDTH] <= wr_data;
                                acc  <= acc + wr_data;
                                wcnt <= wcnt + 1'b1;
                            end
`else
                            shadow[int'(wcnt)*CWIDTH +: CWIDTH] <= wr_data;
                            if (wcnt == LAST_IDX) begin
                                state    <= PENDING;
                                wcnt     <= '0;
                                wr_rdy_q <= 1'b0;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
`endif
                        end
                    end
                    PENDING: begin
                        if (din_vld) begin
                            coefs     <= shadow;
                            coef_upd  <= 1'b1;
                            state     <= IDLE;
                            load_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
